cook_timer_ctrl: RTL and testbench

//  Sequencer for the microwave mm:ss countdown datapath (minutes digit, mod-6 tens-of-seconds, mod-10 ones).

---
 rtl/cook_timer_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_cook_timer_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer_ctrl.sv
// Microwave mm:ss countdown sequencer: keypad entry, counter load/clear, cook/pause/done control.
// Latency: state, loadn, cnt_clrn, mag_on, done and err are registered (1 cycle); count_en and data_* are combinational.
// Backpressure: none; key_valid/sec_tick are single-cycle strobes consumed when legal, and ignored otherwise.
//
// Ports:
//   clk, clrn                 rising-edge clock, synchronous active-low reset
//   sec_tick                  1 Hz one-cycle strobe
//   key_valid, key_digit      keypad strobe and BCD digit
//   start, stop_clear         start/resume and pause/clear requests (levels)
//   door_closed, zero_all     interlock and datapath all-zero status
//   data_min/tens/ones        entry register contents to counter parallel-load inputs
//   loadn, cnt_clrn           active-low load and clear strobes to the counters
//   count_en                  decrement enable into the ones counter
//   mag_on, done, err         magnetron enable, cook-complete, rejected-start pulse
//   state                     current sequencer state
module cook_timer_ctrl #(
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       sec_tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       zero_all,
    output logic [3:0] data_min,
    output logic [3:0] data_tens,
    output logic [3:0] data_ones,
    output logic       loadn,
    output logic       count_en,
    output logic       cnt_clrn,
    output logic       mag_on,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_COOK  = 3'd3;
    localparam logic [2:0] S_PAUSE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

    logic [2:0] state_q;
    logic [2:0] next_state;
    logic [3:0] ent_min;
    logic [3:0] ent_tens;
    logic [3:0] ent_ones;
    logic [3:0] beep_cnt;

    logic key_ok;        // a legal BCD digit was presented
    logic shift_key;     // capture the key into the entry register this cycle
    logic clr_entry;     // zero the entry register (and pulse cnt_clrn)
    logic start_legal;   // entry and door allow a cook to begin
    logic rej_start;     // start requested in ENTRY but refused
    logic beep_inc;      // count a sec_tick while sitting in DONE

    assign key_ok      = key_valid && (key_digit <= 4'd9);
    assign start_legal = door_closed
                         && ({ent_min, ent_tens, ent_ones} != 12'h000)
                         && (ent_tens <= 4'd5);

    always_comb begin
        next_state = state_q;
        shift_key  = 1'b0;
        clr_entry  = 1'b0;
        rej_start  = 1'b0;
        beep_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_ok) begin
                    shift_key  = 1'b1;
                    next_state = S_ENTRY;
                end
            end

            S_ENTRY: begin
                // Clear takes priority over both start and a same-cycle key.
                if (stop_clear) begin
                    clr_entry  = 1'b1;
                    next_state = S_IDLE;
                end else if (start) begin
                    if (start_legal) begin
                        next_state = S_LOAD;
                    end else begin
                        rej_start = 1'b1;
                        shift_key = key_ok;
                    end
                end else begin
                    shift_key = key_ok;
                end
            end

            S_LOAD: begin
                next_state = S_COOK;
            end

            S_COOK: begin
                // Interlock/pause is checked before completion so an open door
                // never lets the sequencer slip into DONE unnoticed.
                if (!door_closed || stop_clear) begin
                    next_state = S_PAUSE;
                end else if (zero_all) begin
                    next_state = S_DONE;
                end
            end

            S_PAUSE: begin
                if (stop_clear) begin
                    clr_entry  = 1'b1;
                    next_state = S_IDLE;
                end else if (start && door_closed) begin
                    next_state = S_COOK;
                end
            end

            S_DONE: begin
                // A keypress here only dismisses the beep; the digit is dropped.
                if (stop_clear || key_valid) begin
                    clr_entry  = 1'b1;
                    next_state = S_IDLE;
                end else if (sec_tick) begin
                    if (beep_cnt >= BEEP_LAST) begin
                        clr_entry  = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        beep_inc = 1'b1;
                    end
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            ent_min  <= 4'd0;
            ent_tens <= 4'd0;
            ent_ones <= 4'd0;
            beep_cnt <= 4'd0;
            loadn    <= 1'b1;
            cnt_clrn <= 1'b0;
            mag_on   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= next_state;

            if (clr_entry) begin
                ent_min  <= 4'd0;
                ent_tens <= 4'd0;
                ent_ones <= 4'd0;
            end else if (shift_key) begin
                ent_min  <= ent_tens;
                ent_tens <= ent_ones;
                ent_ones <= key_digit;
            end

            if (next_state != S_DONE) begin
                beep_cnt <= 4'd0;
            end else if (beep_inc) begin
                beep_cnt <= beep_cnt + 4'd1;
            end

            // Strobes are decoded from next_state so they line up with the
            // cycle the sequencer actually occupies the corresponding state.
            loadn    <= (next_state != S_LOAD);
            cnt_clrn <= !clr_entry;
            mag_on   <= (next_state == S_COOK);
            done     <= (next_state == S_DONE);
            err      <= rej_start;
        end
    end

    // The ones counter only decrements while genuinely cooking; the same-cycle
    // door/stop terms stop the tick that coincides with a pause request.
    assign count_en  = (state_q == S_COOK) && sec_tick && !zero_all
                       && door_closed && !stop_clear;

    assign data_min  = ent_min;
    assign data_tens = ent_tens;
    assign data_ones = ent_ones;
    assign state     = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
module tb_cook_timer_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic       sec_tick;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic       zero_all;
    logic [3:0] data_min;
    logic [3:0] data_tens;
    logic [3:0] data_ones;
    logic       loadn;
    logic       count_en;
    logic       cnt_clrn;
    logic       mag_on;
    logic       done;
    logic       err;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    cook_timer_ctrl #(.BEEP_TICKS(3)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .sec_tick    (sec_tick),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .zero_all    (zero_all),
        .data_min    (data_min),
        .data_tens   (data_tens),
        .data_ones   (data_ones),
        .loadn       (loadn),
        .count_en    (count_en),
        .cnt_clrn    (cnt_clrn),
        .mag_on      (mag_on),
        .done        (done),
        .err         (err),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        step();
        step();
        chk("rst_state", 12'(state), 12'd0);
        chk("rst_mag", 12'(mag_on), 12'd0);
        chk("rst_loadn", 12'(loadn), 12'd1);
        chk("rst_clrn_low", 12'(cnt_clrn), 12'd0);
        chk("rst_data", {data_min, data_tens, data_ones}, 12'h000);
        chk("rst_done_err", 12'({done, err}), 12'd0);
        clrn = 1'b1;
        step();
        chk("rst_clrn_high", 12'(cnt_clrn), 12'd1);
    endtask

    initial begin
        clrn        = 1'b0;
        sec_tick    = 1'b0;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        door_closed = 1'b1;
        zero_all    = 1'b0;
        #2;
        do_reset();

        // T2: enter 1:30 and start
        key(4'd1);
        chk("t2_entry_state", 12'(state), 12'd1);
        key(4'd3);
        key(4'd0);
        chk("t2_data", {data_min, data_tens, data_ones}, 12'h130);
        chk("t2_loadn_pre", 12'(loadn), 12'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_load_state", 12'(state), 12'd2);
        chk("t2_loadn_low", 12'(loadn), 12'd0);
        step();
        chk("t2_cook_state", 12'(state), 12'd3);
        chk("t2_loadn_back", 12'(loadn), 12'd1);
        chk("t2_mag_on", 12'(mag_on), 12'd1);
        chk("t2_cnt_en_idle", 12'(count_en), 12'd0);
        sec_tick = 1'b1;
        #1;
        chk("t2_cnt_en_tick", 12'(count_en), 12'd1);
        step();
        sec_tick = 1'b0;
        #1;
        chk("t2_cnt_en_after", 12'(count_en), 12'd0);

        // T4: door opens on a tick cycle
        door_closed = 1'b0;
        sec_tick    = 1'b1;
        #1;
        chk("t4_cnt_en_door", 12'(count_en), 12'd0);
        step();
        sec_tick = 1'b0;
        chk("t4_pause_state", 12'(state), 12'd4);
        chk("t4_mag_off", 12'(mag_on), 12'd0);
        door_closed = 1'b1;
        start       = 1'b1;
        step();
        start = 1'b0;
        chk("t4_resume_state", 12'(state), 12'd3);
        chk("t4_no_reload", 12'(loadn), 12'd1);
        chk("t4_mag_on", 12'(mag_on), 12'd1);

        // T1: reset in the middle of cooking
        do_reset();

        // T3: tens digit 9 rejected
        key(4'd1);
        key(4'd9);
        key(4'd9);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_err_pulse", 12'(err), 12'd1);
        chk("t3_stay_entry", 12'(state), 12'd1);
        chk("t3_loadn", 12'(loadn), 12'd1);
        step();
        chk("t3_err_clear", 12'(err), 12'd0);
        chk("t3_loadn2", 12'(loadn), 12'd1);
        stop_clear = 1'b1;
        step();
        stop_clear = 1'b0;
        chk("t3_clear_idle", 12'(state), 12'd0);
        chk("t3_clrn_pulse", 12'(cnt_clrn), 12'd0);
        step();
        chk("t3_clrn_back", 12'(cnt_clrn), 12'd1);

        // T3b: door open rejects a valid entry
        door_closed = 1'b0;
        key(4'd0);
        key(4'd3);
        key(4'd0);
        chk("t3b_data", {data_min, data_tens, data_ones}, 12'h030);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3b_err", 12'(err), 12'd1);
        chk("t3b_state", 12'(state), 12'd1);
        step();
        chk("t3b_err_clear", 12'(err), 12'd0);
        door_closed = 1'b1;
        stop_clear  = 1'b1;
        step();
        stop_clear = 1'b0;
        step();

        // T5: 0:02 runs out, beeps three ticks and returns to IDLE
        key(4'd0);
        key(4'd0);
        key(4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_cook", 12'(state), 12'd3);
        for (int i = 0; i < 2; i++) begin
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            step();
        end
        zero_all = 1'b1;
        #1;
        chk("t5_cnt_en_zero", 12'(count_en), 12'd0);
        step();
        chk("t5_done_state", 12'(state), 12'd5);
        chk("t5_done", 12'(done), 12'd1);
        chk("t5_mag_off", 12'(mag_on), 12'd0);
        for (int i = 0; i < 2; i++) begin
            sec_tick = 1'b1;
            step();
            sec_tick = 1'b0;
            step();
        end
        chk("t5_still_done", 12'(state), 12'd5);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
        chk("t5_auto_idle", 12'(state), 12'd0);
        chk("t5_done_low", 12'(done), 12'd0);
        chk("t5_entry_clear", {data_min, data_tens, data_ones}, 12'h000);

        // T5b: stop_clear dismisses DONE at once
        zero_all = 1'b0;
        key(4'd0);
        key(4'd0);
        key(4'd2);
        start = 1'b1;
        step();
        start    = 1'b0;
        zero_all = 1'b1;
        step();
        step();
        chk("t5b_done", 12'(done), 12'd1);
        stop_clear = 1'b1;
        step();
        stop_clear = 1'b0;
        zero_all   = 1'b0;
        chk("t5b_idle", 12'(state), 12'd0);
        chk("t5b_done_low", 12'(done), 12'd0);

        // T6: stop_clear beats start in ENTRY; 4-key overflow; invalid digit
        key(4'd5);
        start      = 1'b1;
        stop_clear = 1'b1;
        step();
        start      = 1'b0;
        stop_clear = 1'b0;
        chk("t6_idle", 12'(state), 12'd0);
        chk("t6_entry_zero", {data_min, data_tens, data_ones}, 12'h000);
        chk("t6_clrn_low", 12'(cnt_clrn), 12'd0);
        chk("t6_no_err", 12'(err), 12'd0);
        step();
        chk("t6_clrn_high", 12'(cnt_clrn), 12'd1);
        chk("t6_no_err2", 12'(err), 12'd0);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        key(4'd4);
        chk("t6_overflow", {data_min, data_tens, data_ones}, 12'h234);
        key(4'd12);
        chk("t6_bad_digit", {data_min, data_tens, data_ones}, 12'h234);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
